// File: rtl/ds_bypass_unit_if.sv
// Fetch-to-decode and decode-to-execute valid/allowin handshake bundle.
// Master drives the fetch payload and execute back-pressure.
interface ds_bypass_unit_if #(
  parameter int PW = 64
);
  logic          fs_to_ds_valid;
  logic [PW-1:0] fs_to_ds_bus;
  logic          ds_allowin;
  logic          es_allowin;
  logic          ds_to_es_valid;
  logic [PW-1:0] ds_payload;

  modport master (
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output es_allowin,
    input  ds_allowin,
    input  ds_to_es_valid,
    input  ds_payload
  );

  modport slave (
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  es_allowin,
    output ds_allowin,
    output ds_to_es_valid,
    output ds_payload
  );
endinterface

// File: rtl/ds_bypass_unit.sv
// Decode-stage operand bypass network with load-use interlock.
// Youngest matching stage wins; register 0 is never forwarded.
module ds_bypass_unit #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSTG = 3,
  parameter int PW   = 64
) (
  input  logic                clk,
  input  logic                reset,
  ds_bypass_unit_if.slave     bus,
  input  logic [AW-1:0]       rs,
  input  logic [AW-1:0]       rt,
  input  logic                rs_used,
  input  logic                rt_used,
  input  logic [DW-1:0]       rf_rdata1,
  input  logic [DW-1:0]       rf_rdata2,
  input  logic [NSTG-1:0]     stg_valid,
  input  logic [NSTG-1:0]     stg_we,
  input  logic [NSTG*AW-1:0]  stg_dest,
  input  logic [NSTG*DW-1:0]  stg_result,
  input  logic [NSTG-1:0]     stg_ready,
  input  logic                ds_flush,
  output logic [DW-1:0]       rs_value,
  output logic [DW-1:0]       rt_value,
  output logic                ds_stall,
  output logic [15:0]         stall_cnt
);

  logic          ds_valid;
  logic [PW-1:0] payload;
  logic          rs_rdy;
  logic          rt_rdy;
  logic          ready_go;
  logic          allowin;
  logic          accept;

  // Scan oldest to youngest so the lowest index overwrites.
  always_comb begin
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
    rs_rdy   = 1'b1;
    rt_rdy   = 1'b1;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (stg_valid[i] && stg_we[i] && rs_used &&
          (rs != '0) && (stg_dest[i*AW +: AW] == rs)) begin
        rs_value = stg_result[i*DW +: DW];
        rs_rdy   = stg_ready[i];
      end
      if (stg_valid[i] && stg_we[i] && rt_used &&
          (rt != '0) && (stg_dest[i*AW +: AW] == rt)) begin
        rt_value = stg_result[i*DW +: DW];
        rt_rdy   = stg_ready[i];
      end
    end
  end

  assign ds_stall = ds_valid & (~rs_rdy | ~rt_rdy);
  assign ready_go = ~ds_stall;
  assign allowin  = ~ds_valid | (ready_go & bus.es_allowin);
  assign accept   = bus.fs_to_ds_valid & allowin & ~ds_flush;

  assign bus.ds_allowin     = allowin;
  assign bus.ds_to_es_valid = ds_valid & ready_go & ~ds_flush;
  assign bus.ds_payload     = payload;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid  <= 1'b0;
      stall_cnt <= 16'h0000;
    end else begin
      if (ds_flush)
        ds_valid <= 1'b0;
      else if (allowin)
        ds_valid <= bus.fs_to_ds_valid;
      if (ds_stall && !ds_flush && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && accept)
      payload <= bus.fs_to_ds_bus;
  end

endmodule
